store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- FIFO write buffer between the Memory stage's store handshake and the data-memory write port.
- The Memory stage holds storeValid with address, shifted data and byte enables until storeComplete; this block accepts the store in one cycle and drains it to memory in the background.
- Also reports load/store address conflicts so the Memory stage can stall a load that reads bytes still pending in the buffer.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, minimum 2.

Ports:
- clock  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-low reset (asserted at 0)
- storeValid  input  1  store request from Memory stage; held high until storeComplete
- addressRegister  input  32  store byte address
- storeData  input  32  lane-aligned store data
- realStoreByteEnable  input  4  lane-aligned byte enables
- storeComplete  output  1  combinational accept strobe
- loadRequest  input  1  Memory stage load is being evaluated this cycle
- loadAddress  input  32  load byte address
- loadByteEnable  input  4  lane-aligned bytes the load reads
- loadHazard  output  1  load overlaps a pending entry; Memory stage must stall
- memWriteValid  output  1  head entry presented to memory
- memWriteAddress  output  32  head address, bits [1:0] forced to 0
- memWriteData  output  32  head data
- memWriteByteEnable  output  4  head byte enables
- memWriteReady  input  1  memory accepts head this cycle
- occupancy  output  $clog2(DEPTH+1)  number of valid entries
- empty  output  1  occupancy == 0; used for fence and interrupt drain

Behaviour:
- Reset (reset=0, async):
  - head, tail and occupancy cleared; all entries invalid.
  - memWriteValid=0, storeComplete=0, loadHazard=0, empty=1.
  - Buffered stores are discarded. Reset mid-drain abandons the in-flight write; memory must tolerate the write-valid drop.
- Enqueue:
  - storeComplete = storeValid && (occupancy < DEPTH), combinational.
  - On that cycle, tail entry <= {addressRegister, storeData, realStoreByteEnable}; tail increments modulo DEPTH.
  - storeComplete is never asserted with storeValid low.
  - One accept per store: the Memory stage drops storeValid on the edge after storeComplete.
- Full:
  - occupancy == DEPTH blocks accept even if a dequeue happens the same cycle. Fullness is registered; there is no same-cycle pass-through.
  - storeComplete returns on the cycle after the dequeue.
- Drain:
  - memWriteValid = !empty. Outputs come from the head entry and stay stable while memWriteValid && !memWriteReady.
  - Dequeue on memWriteValid && memWriteReady; head increments modulo DEPTH.
  - Entries drain strictly in FIFO order; at most one write per cycle.
- Simultaneous enqueue and dequeue (occupancy between 1 and DEPTH-1): occupancy unchanged and both pointers advance.
- An empty buffer ignores memWriteReady.
- Pointer wrap: log2(DEPTH)-bit pointers wrap silently. Full and empty come from the occupancy counter, not pointer equality.
- Load conflict:
  - An entry matches when it is valid, loadAddress[31:2] == entry address[31:2], and (loadByteEnable & entry byte enable) != 0.
  - loadHazard = loadRequest && any match; combinational, same cycle.
  - The entry currently being dequeued still counts as valid that cycle.
  - A store accepted this cycle is not checked, since program order keeps a load out of Memory while an older store is still in handshake.
- Byte enable 4'b0000 entries are legal: stored, drained and never matching.

Optional Feature:
- STORE_BUFFER_FORWARD_EN adds ports forwardValid (1, output) and forwardData (32, output).
- With the macro, forwarding applies when the youngest matching entry's byte enables cover every loadByteEnable bit:
  - forwardValid=1 and forwardData = that entry's data.
  - loadHazard=0 for that load.
- A partial-coverage youngest match gives loadHazard=1 and forwardValid=0.
- Youngest is determined by walking back from tail-1 over occupancy entries.
- Without the macro the ports are absent and every match gives loadHazard.

Test Plan:
- Single store: storeValid=1, addr 0x100, data 0xDEADBEEF, be 4'hF, memWriteReady=1 → storeComplete same cycle; next cycle memWriteValid=1, addr 0x100, data 0xDEADBEEF; then empty=1.
- Fill to full: memWriteReady=0, enqueue 5 stores with DEPTH=4 → four storeComplete pulses, occupancy=4, fifth held with storeComplete=0. Raise memWriteReady for one cycle → fifth accepted the following cycle, drain order matches enqueue order.
- Simultaneous: occupancy=2 with enqueue and dequeue in the same cycle → occupancy stays 2, pointers wrap correctly across 8 iterations.
- Hazard: pending byte store addr 0x203, be 4'b1000. Load addr 0x200, be 4'b0001 → loadHazard=0. Load addr 0x200, be 4'hF → loadHazard=1 (without macro).
- Forwarding (macro on): pending word store 0x300 = 0x11223344, then halfword 0x302, be 4'b1100, data 0xAABB0000. Load 0x302, be 4'b1100 → forwardValid=1, forwardData=0xAABB0000. Load 0x300, be 4'hF → loadHazard=1.
- Async reset with occupancy=3 mid-write → memWriteValid=0 immediately with no clock edge; after release occupancy=0, no stale write issued.

Source files
------------

// File: rtl/store_buffer_if.sv
// Store handshake, load-conflict query and data-memory write port of the store buffer.
// STORE_BUFFER_FORWARD_EN adds the forwardValid/forwardData load-forwarding signals.
interface store_buffer_if #(
    parameter int DEPTH = 4
);
    logic                       storeValid;
    logic [31:0]                addressRegister;
    logic [31:0]                storeData;
    logic [3:0]                 realStoreByteEnable;
    logic                       storeComplete;
    logic                       loadRequest;
    logic [31:0]                loadAddress;
    logic [3:0]                 loadByteEnable;
    logic                       loadHazard;
    logic                       memWriteValid;
    logic [31:0]                memWriteAddress;
    logic [31:0]                memWriteData;
    logic [3:0]                 memWriteByteEnable;
    logic                       memWriteReady;
    logic [$clog2(DEPTH+1)-1:0] occupancy;
    logic                       empty;
`ifdef STORE_BUFFER_FORWARD_EN
    logic                       forwardValid;
    logic [31:0]                forwardData;
`endif

    // Buffer side.
    modport slave (
        input  storeValid, addressRegister, storeData, realStoreByteEnable,
        input  loadRequest, loadAddress, loadByteEnable, memWriteReady,
        output storeComplete, loadHazard, memWriteValid, memWriteAddress,
        output memWriteData, memWriteByteEnable, occupancy, empty
`ifdef STORE_BUFFER_FORWARD_EN
        , output forwardValid, forwardData
`endif
    );

    // Memory stage and data-memory side.
    modport master (
        output storeValid, addressRegister, storeData, realStoreByteEnable,
        output loadRequest, loadAddress, loadByteEnable, memWriteReady,
        input  storeComplete, loadHazard, memWriteValid, memWriteAddress,
        input  memWriteData, memWriteByteEnable, occupancy, empty
`ifdef STORE_BUFFER_FORWARD_EN
        , input forwardValid, forwardData
`endif
    );
endinterface

// File: rtl/store_buffer.sv
// FIFO store buffer: single-cycle store accept, background drain to data memory, load-conflict detection.
// Define STORE_BUFFER_FORWARD_EN to forward data from a fully covering youngest matching entry.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input logic           clock,
    input logic           reset,
    store_buffer_if.slave sb
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0] head_reg, tail_reg;
    logic [OCC_W-1:0] occ_reg, occ_next;
    logic [29:0]      addr_mem [DEPTH];
    logic [31:0]      data_mem [DEPTH];
    logic [3:0]       be_mem   [DEPTH];

    logic enq, deq;
    logic unused_addr_lsbs;

    assign unused_addr_lsbs = ^{sb.addressRegister[1:0], sb.loadAddress[1:0]};

    // Fullness is registered, so a same-cycle dequeue never frees a slot for the current store.
    assign enq = reset && sb.storeValid && (occ_reg < OCC_W'(DEPTH));
    assign deq = (occ_reg != '0) && sb.memWriteReady;

    always_comb begin
        occ_next = occ_reg;
        if (enq && !deq) begin
            occ_next = occ_reg + OCC_W'(1);
        end else if (!enq && deq) begin
            occ_next = occ_reg - OCC_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_reg <= '0;
            tail_reg <= '0;
            occ_reg  <= '0;
        end else begin
            occ_reg <= occ_next;
            if (enq) tail_reg <= tail_reg + PTR_W'(1);
            if (deq) head_reg <= head_reg + PTR_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (enq) begin
            addr_mem[tail_reg] <= sb.addressRegister[31:2];
            data_mem[tail_reg] <= sb.storeData;
            be_mem[tail_reg]   <= sb.realStoreByteEnable;
        end
    end

    assign sb.storeComplete      = enq;
    assign sb.occupancy          = occ_reg;
    assign sb.empty              = (occ_reg == '0);
    assign sb.memWriteValid      = (occ_reg != '0);
    assign sb.memWriteAddress    = {addr_mem[head_reg], 2'b00};
    assign sb.memWriteData       = data_mem[head_reg];
    assign sb.memWriteByteEnable = be_mem[head_reg];

    // Entries indexed by age: age 0 is the youngest (tail-1), valid while age < occupancy.
    logic [PTR_W-1:0] age_idx [DEPTH];
    logic [DEPTH-1:0] age_match;
`ifdef STORE_BUFFER_FORWARD_EN
    logic [DEPTH-1:0] age_cover;
    logic [31:0]      age_data [DEPTH];
`endif

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
            assign age_idx[gi]   = tail_reg - PTR_W'(gi + 1);
            assign age_match[gi] = (OCC_W'(gi) < occ_reg)
                                && (addr_mem[age_idx[gi]] == sb.loadAddress[31:2])
                                && ((be_mem[age_idx[gi]] & sb.loadByteEnable) != 4'b0000);
`ifdef STORE_BUFFER_FORWARD_EN
            assign age_cover[gi] = ((be_mem[age_idx[gi]] & sb.loadByteEnable) == sb.loadByteEnable);
            assign age_data[gi]  = data_mem[age_idx[gi]];
`endif
        end
    endgenerate

`ifdef STORE_BUFFER_FORWARD_EN
    logic        fwd_found, fwd_hit;
    logic [31:0] fwd_data;

    always_comb begin
        fwd_found = 1'b0;
        fwd_hit   = 1'b0;
        fwd_data  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!fwd_found && age_match[k]) begin
                fwd_found = 1'b1;
                fwd_hit   = age_cover[k];
                fwd_data  = age_data[k];
            end
        end
    end

    assign sb.loadHazard   = reset && sb.loadRequest && fwd_found && !fwd_hit;
    assign sb.forwardValid = reset && sb.loadRequest && fwd_found && fwd_hit;
    assign sb.forwardData  = fwd_data;
`else
    assign sb.loadHazard = reset && sb.loadRequest && (age_match != '0);
`endif
endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: expected memory writes are queued at issue and checked by a monitor.
module tb_store_buffer;
    localparam int DEPTH = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    store_buffer_if #(.DEPTH(DEPTH)) sb ();
    store_buffer #(.DEPTH(DEPTH)) dut (.clock(clock), .reset(reset), .sb(sb.slave));

    int checks   = 0;
    int failures = 0;
    logic [67:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        exp_q.push_back({a & 32'hFFFF_FFFC, d, be});
        sb.storeValid          = 1'b1;
        sb.addressRegister     = a;
        sb.storeData           = d;
        sb.realStoreByteEnable = be;
    endtask

    // Issue one store and hold it until accepted or the budget runs out.
    task automatic store_one(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                             input int budget);
        int n = 0;
        drive_store(a, d, be);
        #3;
        while (!sb.storeComplete && n < budget) begin
            tick();
            #3;
            n++;
        end
        checks++;
        if (!sb.storeComplete) begin
            failures++;
            $display("FAIL accept_%08h got=0 exp=1", a);
            exp_q.delete(exp_q.size() - 1);
        end
        tick();
        sb.storeValid = 1'b0;
    endtask

    task automatic wait_empty(input int budget);
        int n = 0;
        #3;
        while (!sb.empty && n < budget) begin
            tick();
            #3;
            n++;
        end
        check("drain_empty", 32'(sb.empty), 32'd1);
        tick();
    endtask

    // Monitor: every write the memory accepts is compared against the oldest expected store.
    initial begin
        logic [67:0] got, e;
        forever begin
            @(negedge clock);
            if (reset && sb.memWriteValid && sb.memWriteReady) begin
                got = {sb.memWriteAddress, sb.memWriteData, sb.memWriteByteEnable};
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_write got=%017h exp=none", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        failures++;
                        $display("FAIL mem_write got=%017h exp=%017h", got, e);
                    end else begin
                        $display("write addr=%08h data=%08h be=%h", sb.memWriteAddress,
                                 sb.memWriteData, sb.memWriteByteEnable);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sb.storeValid = 1'b1;
        sb.addressRegister = 32'h0;
        sb.storeData = 32'h0;
        sb.realStoreByteEnable = 4'hF;
        sb.loadRequest = 1'b1;
        sb.loadAddress = 32'h0;
        sb.loadByteEnable = 4'hF;
        sb.memWriteReady = 1'b1;

        // Reset state, with requests held high to show the strobes stay low.
        #4;
        check("rst_wvalid", 32'(sb.memWriteValid), 32'd0);
        check("rst_empty", 32'(sb.empty), 32'd1);
        check("rst_occ", 32'(sb.occupancy), 32'd0);
        check("rst_complete", 32'(sb.storeComplete), 32'd0);
        check("rst_hazard", 32'(sb.loadHazard), 32'd0);
        sb.storeValid = 1'b0;
        sb.loadRequest = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // Single store.
        drive_store(32'h100, 32'hDEADBEEF, 4'hF);
        #3;
        check("t1_complete", 32'(sb.storeComplete), 32'd1);
        tick();
        sb.storeValid = 1'b0;
        #3;
        check("t1_wvalid", 32'(sb.memWriteValid), 32'd1);
        check("t1_waddr", sb.memWriteAddress, 32'h100);
        check("t1_wdata", sb.memWriteData, 32'hDEADBEEF);
        tick();
        #3;
        check("t1_empty", 32'(sb.empty), 32'd1);
        tick();

        // Fill to full, fifth store held until a slot frees.
        sb.memWriteReady = 1'b0;
        for (int i = 0; i < 4; i++) store_one(32'h1000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'hF, 0);
        drive_store(32'h1010, 32'hA000_0004, 4'hF);
        #3;
        check("t2_occ_full", 32'(sb.occupancy), 32'd4);
        check("t2_blocked", 32'(sb.storeComplete), 32'd0);
        tick();
        sb.memWriteReady = 1'b1;
        #3;
        check("t2_blocked_deq", 32'(sb.storeComplete), 32'd0);
        tick();
        sb.memWriteReady = 1'b0;
        #3;
        check("t2_occ_after_deq", 32'(sb.occupancy), 32'd3);
        check("t2_fifth_accept", 32'(sb.storeComplete), 32'd1);
        tick();
        sb.storeValid = 1'b0;
        #3;
        check("t2_occ_refull", 32'(sb.occupancy), 32'd4);
        tick();
        sb.memWriteReady = 1'b1;
        wait_empty(20);

        // Simultaneous enqueue and dequeue at occupancy 2 across pointer wrap.
        sb.memWriteReady = 1'b0;
        store_one(32'h2000, 32'hB000_0000, 4'hF, 0);
        store_one(32'h2004, 32'hB000_0001, 4'hF, 0);
        sb.memWriteReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_store(32'h2008 + 32'(i * 4), 32'hC000_0000 + 32'(i), 4'(i + 1));
            #3;
            check($sformatf("t3_complete_%0d", i), 32'(sb.storeComplete), 32'd1);
            check($sformatf("t3_occ_%0d", i), 32'(sb.occupancy), 32'd2);
            tick();
        end
        sb.storeValid = 1'b0;
        wait_empty(10);

        // Load hazard detection.
        sb.memWriteReady = 1'b0;
        store_one(32'h203, 32'hAA00_0000, 4'b1000, 0);
        store_one(32'h400, 32'h1234_5678, 4'b0000, 0);
        sb.loadRequest = 1'b1;
        sb.loadAddress = 32'h200;
        sb.loadByteEnable = 4'b0001;
        #3;
        check("t4_disjoint_bytes", 32'(sb.loadHazard), 32'd0);
        tick();
        sb.loadByteEnable = 4'hF;
        #3;
        check("t4_overlap", 32'(sb.loadHazard), 32'd1);
        tick();
        sb.loadRequest = 1'b0;
        #3;
        check("t4_no_request", 32'(sb.loadHazard), 32'd0);
        tick();
        sb.loadRequest = 1'b1;
        sb.loadAddress = 32'h204;
        #3;
        check("t4_other_word", 32'(sb.loadHazard), 32'd0);
        tick();
        sb.loadAddress = 32'h400;
        #3;
        check("t4_zero_be_entry", 32'(sb.loadHazard), 32'd0);
        tick();
        sb.loadAddress = 32'h200;
        sb.memWriteReady = 1'b1;
        #3;
        check("t4_dequeuing_entry", 32'(sb.loadHazard), 32'd1);
        tick();
        #3;
        check("t4_after_dequeue", 32'(sb.loadHazard), 32'd0);
        tick();
        sb.loadRequest = 1'b0;
        wait_empty(10);

`ifdef STORE_BUFFER_FORWARD_EN
        // Forwarding from the youngest fully covering entry.
        sb.memWriteReady = 1'b0;
        store_one(32'h300, 32'h1122_3344, 4'hF, 0);
        store_one(32'h302, 32'hAABB_0000, 4'b1100, 0);
        sb.loadRequest = 1'b1;
        sb.loadAddress = 32'h302;
        sb.loadByteEnable = 4'b1100;
        #3;
        check("t5_fwd_valid", 32'(sb.forwardValid), 32'd1);
        check("t5_fwd_data", sb.forwardData, 32'hAABB_0000);
        check("t5_fwd_no_hazard", 32'(sb.loadHazard), 32'd0);
        tick();
        sb.loadAddress = 32'h300;
        sb.loadByteEnable = 4'hF;
        #3;
        check("t5_partial_hazard", 32'(sb.loadHazard), 32'd1);
        check("t5_partial_nofwd", 32'(sb.forwardValid), 32'd0);
        tick();
        sb.loadByteEnable = 4'b0011;
        #3;
        check("t5_older_fwd_valid", 32'(sb.forwardValid), 32'd1);
        check("t5_older_fwd_data", sb.forwardData, 32'h1122_3344);
        tick();
        sb.loadRequest = 1'b0;
        sb.memWriteReady = 1'b1;
        wait_empty(10);
`endif

        // Asynchronous reset with three pending stores while the head is being written.
        sb.memWriteReady = 1'b0;
        for (int i = 0; i < 3; i++) store_one(32'h600 + 32'(i * 4), 32'hD000_0000 + 32'(i), 4'hF, 0);
        #3;
        check("t6_occ3", 32'(sb.occupancy), 32'd3);
        tick();
        sb.memWriteReady = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        check("t6_async_wvalid", 32'(sb.memWriteValid), 32'd0);
        check("t6_async_empty", 32'(sb.empty), 32'd1);
        check("t6_async_occ", 32'(sb.occupancy), 32'd0);
        exp_q.delete();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #3;
            check($sformatf("t6_no_stale_%0d", i), 32'(sb.memWriteValid), 32'd0);
            tick();
        end
        store_one(32'h700, 32'hFEED_F00D, 4'b0110, 0);
        wait_empty(10);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
